// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// dmem_pkg : access-size encodings, controller state enum and size helper
// Revision : 1.0
// ============================================================================
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE   = 2'b00,
    SZ_HALF   = 2'b01,
    SZ_WORD   = 2'b10,
    SZ_DOUBLE = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    DONE = 2'b10
  } state_e;

  function automatic logic [3:0] bytes_of(input size_e s);
    case (s)
      SZ_BYTE: bytes_of = 4'd1;
      SZ_HALF: bytes_of = 4'd2;
      SZ_WORD: bytes_of = 4'd4;
      default: bytes_of = 4'd8;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_lane_align.sv
`default_nettype none
// ============================================================================
// dmem_lane_align : store byte-enables/lane shift and load extract + extension
// Revision : 1.0
// ============================================================================
module dmem_lane_align
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int OFF_BITS   = $clog2(DATA_WIDTH / 8)
) (
  input  logic [OFF_BITS-1:0]     offset,
  input  size_e                   size,
  input  logic                    is_unsigned,
  input  logic [DATA_WIDTH-1:0]   store_data,
  input  logic [DATA_WIDTH-1:0]   read_word,
  output logic [DATA_WIDTH-1:0]   store_word,
  output logic [DATA_WIDTH/8-1:0] byte_en,
  output logic [DATA_WIDTH-1:0]   load_data
);

  localparam int DB = DATA_WIDTH / 8;
  localparam logic [DATA_WIDTH-1:0] M8  = DATA_WIDTH'(8'hFF);
  localparam logic [DATA_WIDTH-1:0] M16 = DATA_WIDTH'(16'hFFFF);
  localparam logic [DATA_WIDTH-1:0] M32 = DATA_WIDTH'(32'hFFFF_FFFF);

  logic [DB-1:0]         size_mask;
  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] low_mask;
  logic                  sign_bit;

  always_comb begin
    case (size)
      SZ_BYTE: size_mask = DB'(8'h01);
      SZ_HALF: size_mask = DB'(8'h03);
      SZ_WORD: size_mask = DB'(8'h0F);
      default: size_mask = DB'(8'hFF);
    endcase
    byte_en    = size_mask << offset;
    store_word = store_data << {offset, 3'b000};
  end

  // Bits above the access size are filled with the sign bit unless zero-extending.
  always_comb begin
    shifted = read_word >> {offset, 3'b000};
    case (size)
      SZ_BYTE: begin low_mask = M8;  sign_bit = shifted[7];  end
      SZ_HALF: begin low_mask = M16; sign_bit = shifted[15]; end
      SZ_WORD: begin low_mask = M32; sign_bit = shifted[31]; end
      default: begin low_mask = '1;  sign_bit = 1'b0;        end
    endcase
    load_data = (shifted & low_mask) |
                ({DATA_WIDTH{sign_bit & ~is_unsigned}} & ~low_mask);
  end

endmodule
`default_nettype wire

// File: rtl/data_memory_ctrl.sv
`default_nettype none
// ============================================================================
// data_memory_ctrl : byte-addressed data memory with wait states and handshake
// Optional macro DMEM_ACCESS_COUNT_EN adds LoadCount/StoreCount outputs.
// Revision : 1.0
// ============================================================================
module data_memory_ctrl
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH     = 64,
  parameter int ADDR_WIDTH     = 64,
  parameter int MEM_BYTES_LOG2 = 12,
  parameter int WAIT_CYCLES    = 2
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [ADDR_WIDTH-1:0] Address,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [1:0]            Size,
  input  logic                  Unsigned,
  output logic                  Ready,
  output logic                  Valid,
  output logic [DATA_WIDTH-1:0] ReadData,
  output logic                  Misaligned
`ifdef DMEM_ACCESS_COUNT_EN
  ,
  output logic [31:0]           LoadCount,
  output logic [31:0]           StoreCount
`endif
);

  localparam int DB       = DATA_WIDTH / 8;
  localparam int OFF_BITS = $clog2(DB);
  localparam int IDX_W    = MEM_BYTES_LOG2 - OFF_BITS;
  localparam int WORDS    = 2 ** IDX_W;

  state_e                    state_q, state_d;
  logic [3:0]                cnt_q, cnt_d;
  logic [MEM_BYTES_LOG2-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
  size_e                     size_q, size_d;
  logic                      uns_q, uns_d;
  logic                      store_q, store_d;
  logic                      valid_q, valid_d;
  logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;
  logic                      misal_q, misal_d;
`ifdef DMEM_ACCESS_COUNT_EN
  logic [31:0]               load_cnt_q, load_cnt_d;
  logic [31:0]               store_cnt_q, store_cnt_d;
`endif

  logic [DATA_WIDTH-1:0] mem [WORDS];
  logic [IDX_W-1:0]      word_idx;
  logic [OFF_BITS-1:0]   byte_off;
  logic [DATA_WIDTH-1:0] read_word;
  logic [DATA_WIDTH-1:0] store_word;
  logic [DB-1:0]         byte_en;
  logic [DATA_WIDTH-1:0] load_data;
  logic [3:0]            off_mask;
  logic                  misaligned_now;
  logic                  mem_we;

  assign word_idx  = addr_q[MEM_BYTES_LOG2-1:OFF_BITS];
  assign byte_off  = addr_q[OFF_BITS-1:0];
  assign read_word = mem[word_idx];
  assign off_mask  = bytes_of(size_q) - 4'd1;
  assign misaligned_now = (|(addr_q[3:0] & off_mask)) ||
                          (size_q == SZ_DOUBLE && DATA_WIDTH == 32);

  dmem_lane_align #(
    .DATA_WIDTH (DATA_WIDTH),
    .OFF_BITS   (OFF_BITS)
  ) u_lane_align (
    .offset      (byte_off),
    .size        (size_q),
    .is_unsigned (uns_q),
    .store_data  (wdata_q),
    .read_word   (read_word),
    .store_word  (store_word),
    .byte_en     (byte_en),
    .load_data   (load_data)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    uns_d   = uns_q;
    store_d = store_q;
    valid_d = 1'b0;
    rdata_d = rdata_q;
    misal_d = misal_q;
    mem_we  = 1'b0;
`ifdef DMEM_ACCESS_COUNT_EN
    load_cnt_d  = load_cnt_q;
    store_cnt_d = store_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (MemRead || MemWrite) begin
          addr_d  = Address[MEM_BYTES_LOG2-1:0];
          wdata_d = WriteData;
          size_d  = size_e'(Size);
          uns_d   = Unsigned;
          store_d = MemWrite;
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = DONE;
          valid_d = 1'b1;
          misal_d = misaligned_now;
          rdata_d = '0;
          if (!misaligned_now) begin
            if (store_q) begin
              mem_we = 1'b1;
`ifdef DMEM_ACCESS_COUNT_EN
              if (store_cnt_q != 32'hFFFF_FFFF) store_cnt_d = store_cnt_q + 32'd1;
`endif
            end else begin
              rdata_d = load_data;
`ifdef DMEM_ACCESS_COUNT_EN
              if (load_cnt_q != 32'hFFFF_FFFF) load_cnt_d = load_cnt_q + 32'd1;
`endif
            end
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= SZ_BYTE;
      uns_q   <= 1'b0;
      store_q <= 1'b0;
      valid_q <= 1'b0;
      rdata_q <= '0;
      misal_q <= 1'b0;
`ifdef DMEM_ACCESS_COUNT_EN
      load_cnt_q  <= '0;
      store_cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      store_q <= store_d;
      valid_q <= valid_d;
      rdata_q <= rdata_d;
      misal_q <= misal_d;
`ifdef DMEM_ACCESS_COUNT_EN
      load_cnt_q  <= load_cnt_d;
      store_cnt_q <= store_cnt_d;
`endif
    end
  end

  // Array contents survive reset; a reset mid-access leaves state IDLE so no write fires.
  always_ff @(posedge Clock) begin
    if (mem_we) begin
      for (int b = 0; b < DB; b++) begin
        if (byte_en[b]) mem[word_idx][b*8 +: 8] <= store_word[b*8 +: 8];
      end
    end
  end

  assign Ready      = (state_q == IDLE);
  assign Valid      = valid_q;
  assign ReadData   = rdata_q;
  assign Misaligned = misal_q;
`ifdef DMEM_ACCESS_COUNT_EN
  assign LoadCount  = load_cnt_q;
  assign StoreCount = store_cnt_q;
`endif

endmodule
`default_nettype wire
